barrett_reduce_pipe: RTL and testbench

//  Pipelined, multi-lane, signed Barrett reduction modulo Q with a valid/ready stream interface.

---
 rtl/barrett_reduce_pipe_if.sv | 22 ++
 rtl/barrett_reduce_pipe.sv | 95 +++++++++
 tb/tb_barrett_reduce_pipe.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrett_reduce_pipe_if.sv
// Valid/ready stream bundle for barrett_reduce_pipe.
// The input-beat side and the output-beat side share one interface; the DUT takes the slave view.
interface barrett_reduce_pipe_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int TAG_W = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0][WIDTH-1:0] in_data;
  logic                        in_full;
  logic [TAG_W-1:0]            in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0][WIDTH-1:0] out_data;
  logic [TAG_W-1:0]            out_tag;

  modport master (output in_valid, in_data, in_full, in_tag, out_ready,
                  input  in_ready, out_valid, out_data, out_tag);
  modport slave  (input  in_valid, in_data, in_full, in_tag, out_ready,
                  output in_ready, out_valid, out_data, out_tag);
endinterface

// File: rtl/barrett_reduce_pipe.sv
// Three-stage multi-lane signed Barrett reduction mod Q with a valid/ready stream.
// Per-lane datapath lives in barrett_lane; control (valid/full/tag) is shared across lanes.
module barrett_lane #(
  parameter int WIDTH = 16,
  parameter int Q     = 3329,
  parameter int SHIFT = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    full,
  input  logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] res
);
  localparam int     PW = WIDTH + SHIFT + 2;
  localparam int     WR = WIDTH + 2;
  localparam longint V  = ((longint'(1) << SHIFT) + longint'(Q / 2)) / longint'(Q);

  localparam logic signed [PW-1:0]    VP  = PW'(V);
  localparam logic signed [PW-1:0]    RND = PW'(longint'(1) << (SHIFT - 1));
  localparam logic signed [WR-1:0]    QR  = WR'(Q);
  localparam logic signed [WIDTH-1:0] QW  = WIDTH'(Q);

  logic signed [WIDTH-1:0] a1;
  logic signed [WR-1:0]    t1;
  logic signed [WIDTH-1:0] r2;

  // Only the quotient bits of V*a+round are kept; t is small enough for WIDTH+2 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1  <= '0;
      t1  <= '0;
      r2  <= '0;
      res <= '0;
    end else if (en) begin
      a1  <= a;
      t1  <= WR'((PW'(a) * VP + RND) >>> SHIFT);
      r2  <= WIDTH'(WR'(a1) - t1 * QR);
      res <= (full && r2[WIDTH-1]) ? r2 + QW : r2;
    end
  end
endmodule

module barrett_reduce_pipe #(
  parameter int WIDTH = 16,
  parameter int Q     = 3329,
  parameter int SHIFT = 26,
  parameter int LANES = 2,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  barrett_reduce_pipe_if.slave bus,
  output logic                 busy
);
  localparam int STAGES = 3;

  logic [STAGES:1]              vld_pipe;
  logic [STAGES-1:1]            full_pipe;
  logic [STAGES:1][TAG_W-1:0]   tag_pipe;
  logic [LANES-1:0][WIDTH-1:0]  lane_res;
  logic                         en;

  // Whole pipe advances in lockstep; bubbles are not collapsed.
  assign en           = ~vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      full_pipe <= '0;
      tag_pipe  <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], bus.in_valid};
      full_pipe <= {full_pipe[STAGES-2:1], bus.in_full};
      tag_pipe  <= {tag_pipe[STAGES-1:1], bus.in_tag};
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    barrett_lane #(.WIDTH(WIDTH), .Q(Q), .SHIFT(SHIFT)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .full (full_pipe[STAGES-1]),
      .a    (bus.in_data[i]),
      .res  (lane_res[i])
    );
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = lane_res;
  assign bus.out_tag   = tag_pipe[STAGES];
  assign busy          = |vld_pipe;
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed bench for barrett_reduce_pipe: reset, reduction values, boundaries, stalls,
// mid-stream reset, and a strided congruence/range sweep on a 2-lane Q=3329 and a 4-lane Q=7681 build.
module tb_barrett_reduce_pipe;
  localparam int W  = 16;
  localparam int L  = 2;
  localparam int TW = 4;
  localparam int Q  = 3329;
  localparam int L4 = 4;
  localparam int Q4 = 7681;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy4;
  int   n_chk = 0;
  int   n_fail = 0;

  barrett_reduce_pipe_if #(.WIDTH(W), .LANES(L),  .TAG_W(TW)) bi ();
  barrett_reduce_pipe_if #(.WIDTH(W), .LANES(L4), .TAG_W(TW)) bi4 ();

  barrett_reduce_pipe #(.WIDTH(W), .Q(Q), .SHIFT(26), .LANES(L), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bi.slave), .busy(busy));
  barrett_reduce_pipe #(.WIDTH(W), .Q(Q4), .SHIFT(26), .LANES(L4), .TAG_W(TW)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bi4.slave), .busy(busy4));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain modular reference, independent of the Barrett formulation.
  function automatic int ref_red(input int a, input bit full, input int q);
    int m;
    m = a % q;
    if (m < 0) m += q;
    if (!full && m > (q - 1) / 2) m -= q;
    return m;
  endfunction

  // Drives one beat into an empty pipe and returns the first beat that appears on the output.
  task automatic send_and_get(input logic signed [W-1:0] a0, input logic signed [W-1:0] a1,
                              input logic full, input logic [TW-1:0] tag,
                              output logic signed [W-1:0] o0, output logic signed [W-1:0] o1,
                              output logic [TW-1:0] otag, output int lat);
    bi.in_valid = 1'b1; bi.in_data[0] = a0; bi.in_data[1] = a1;
    bi.in_full = full; bi.in_tag = tag; bi.out_ready = 1'b1;
    tick();
    bi.in_valid = 1'b0;
    lat = 1;
    while (!bi.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    o0 = bi.out_data[0]; o1 = bi.out_data[1]; otag = bi.out_tag;
    if (!bi.out_valid) lat = -1;
    tick();
  endtask

  task automatic test_reset();
    bi.out_ready = 1'b0;
    tick(); tick();
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bi.out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (bi.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", bi.out_data); end
    n_chk++; if (bi.out_tag !== '0) begin n_fail++; $display("FAIL rst_out_tag: got %h want 0", bi.out_tag); end
    n_chk++; if (bi.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bi.in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic signed [W-1:0] o0, o1; logic [TW-1:0] ot; int lat;
    send_and_get(16'sd3329, 16'sd0, 1'b0, 4'h5, o0, o1, ot, lat);
    n_chk++; if (o0 !== 0) begin n_fail++; $display("FAIL basic_l0: got %0d want 0", o0); end
    n_chk++; if (o1 !== 0) begin n_fail++; $display("FAIL basic_l1: got %0d want 0", o1); end
    n_chk++; if (ot !== 4'h5) begin n_fail++; $display("FAIL basic_tag: got %0d want 5", ot); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", bi.out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_modes();
    logic signed [W-1:0] o0, o1; logic [TW-1:0] ot; int lat;
    send_and_get(-16'sd32768, 16'sd32767, 1'b0, 4'h1, o0, o1, ot, lat);
    n_chk++; if (o0 !== 522) begin n_fail++; $display("FAIL centred_min: got %0d want 522", o0); end
    n_chk++; if (o1 !== -523) begin n_fail++; $display("FAIL centred_max: got %0d want -523", o1); end
    send_and_get(-16'sd32768, 16'sd32767, 1'b1, 4'h2, o0, o1, ot, lat);
    n_chk++; if (o0 !== 522) begin n_fail++; $display("FAIL full_min: got %0d want 522", o0); end
    n_chk++; if (o1 !== 2806) begin n_fail++; $display("FAIL full_max: got %0d want 2806", o1); end
    n_chk++; if (ot !== 4'h2) begin n_fail++; $display("FAIL full_tag: got %0d want 2", ot); end
  endtask

  task automatic test_boundary();
    logic signed [W-1:0] o0, o1; logic [TW-1:0] ot; int lat;
    send_and_get(16'sd1664, 16'sd1665, 1'b0, 4'h3, o0, o1, ot, lat);
    n_chk++; if (o0 !== 1664) begin n_fail++; $display("FAIL bnd_1664: got %0d want 1664", o0); end
    n_chk++; if (o1 !== -1664) begin n_fail++; $display("FAIL bnd_1665_c: got %0d want -1664", o1); end
    send_and_get(16'sd1665, -16'sd1665, 1'b1, 4'h4, o0, o1, ot, lat);
    n_chk++; if (o0 !== 1665) begin n_fail++; $display("FAIL bnd_1665_f: got %0d want 1665", o0); end
    n_chk++; if (o1 !== 1664) begin n_fail++; $display("FAIL bnd_m1665_f: got %0d want 1664", o1); end
    send_and_get(-16'sd1665, -16'sd1, 1'b0, 4'h6, o0, o1, ot, lat);
    n_chk++; if (o0 !== 1664) begin n_fail++; $display("FAIL bnd_m1665_c: got %0d want 1664", o0); end
    n_chk++; if (o1 !== -1) begin n_fail++; $display("FAIL bnd_m1_c: got %0d want -1", o1); end
    send_and_get(16'sd3328, -16'sd1, 1'b1, 4'h7, o0, o1, ot, lat);
    n_chk++; if (o0 !== 3328) begin n_fail++; $display("FAIL bnd_3328_f: got %0d want 3328", o0); end
    n_chk++; if (o1 !== 3328) begin n_fail++; $display("FAIL bnd_m1_f: got %0d want 3328", o1); end
    send_and_get(16'sd3328, -16'sd3329, 1'b0, 4'h8, o0, o1, ot, lat);
    n_chk++; if (o0 !== -1) begin n_fail++; $display("FAIL bnd_3328_c: got %0d want -1", o0); end
    n_chk++; if (o1 !== 0) begin n_fail++; $display("FAIL bnd_m3329_c: got %0d want 0", o1); end
  endtask

  task automatic test_back_to_back();
    int da[8][2] = '{'{1000, -1000}, '{12345, -12345}, '{32767, -1}, '{-32768, 1},
                     '{7, 3328}, '{-20000, 20000}, '{1, 2}, '{4096, -4096}};
    int in_i = 0, out_i = 0, cyc = 0;
    logic held = 1'b0;
    logic [L-1:0][W-1:0] hd = '0;
    logic [TW-1:0] ht = '0;
    logic signed [W-1:0] ov;
    int exp_v;
    while (out_i < 8 && cyc < 200) begin
      if (held) begin
        n_chk++;
        if (bi.out_valid !== 1'b1 || bi.out_data !== hd || bi.out_tag !== ht) begin
          n_fail++; $display("FAIL b2b_stall_hold: got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                             bi.out_valid, bi.out_data, bi.out_tag, hd, ht);
        end
      end
      bi.out_ready = 1'($urandom_range(0, 1));
      bi.in_valid  = (in_i < 8);
      if (in_i < 8) begin
        bi.in_data[0] = W'(da[in_i][0]); bi.in_data[1] = W'(da[in_i][1]);
        bi.in_tag = TW'(in_i); bi.in_full = 1'(in_i % 2);
      end
      #1;
      n_chk++;
      if (bi.in_ready !== (~bi.out_valid | bi.out_ready)) begin
        n_fail++; $display("FAIL b2b_in_ready: got %b want %b", bi.in_ready, ~bi.out_valid | bi.out_ready);
      end
      if (bi.out_valid && bi.out_ready) begin
        n_chk++;
        if (bi.out_tag !== TW'(out_i)) begin n_fail++; $display("FAIL b2b_order: got tag %0d want %0d", bi.out_tag, out_i); end
        for (int i = 0; i < L; i++) begin
          ov = bi.out_data[i];
          exp_v = ref_red(da[out_i][i], 1'(out_i % 2), Q);
          n_chk++;
          if (ov !== exp_v) begin n_fail++; $display("FAIL b2b_data: beat %0d lane %0d got %0d want %0d", out_i, i, ov, exp_v); end
        end
        out_i++;
      end
      held = bi.out_valid && !bi.out_ready;
      hd = bi.out_data; ht = bi.out_tag;
      if (bi.in_valid && bi.in_ready) in_i++;
      tick();
      cyc++;
    end
    n_chk++; if (out_i != 8) begin n_fail++; $display("FAIL b2b_timeout: got %0d beats want 8", out_i); end
    bi.in_valid = 1'b0; bi.out_ready = 1'b1;
    tick(); tick(); tick();
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_duplicate: got out_valid %b want 0", bi.out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_midstream();
    logic signed [W-1:0] o0, o1; logic [TW-1:0] ot; int lat;
    bi.out_ready = 1'b1; bi.in_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bi.in_valid = 1'b1; bi.in_data[0] = W'(100 + k); bi.in_data[1] = W'(200 + k); bi.in_tag = TW'(9 + k);
      tick();
    end
    bi.in_valid = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    n_chk++; if (bi.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before: got %b want 1", bi.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", bi.out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy: got %b want 0", busy); end
    n_chk++; if (bi.out_data !== '0 || bi.out_tag !== '0) begin
      n_fail++; $display("FAIL mid_async_data: got %h/%0d want 0/0", bi.out_data, bi.out_tag);
    end
    tick(); tick();
    rst_n = 1'b1;
    send_and_get(16'sd1665, -16'sd32768, 1'b1, 4'hC, o0, o1, ot, lat);
    n_chk++; if (ot !== 4'hC) begin n_fail++; $display("FAIL mid_stale_tag: got %0d want 12", ot); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL mid_latency: got %0d want 3", lat); end
    n_chk++; if (o0 !== 1665) begin n_fail++; $display("FAIL mid_l0: got %0d want 1665", o0); end
    n_chk++; if (o1 !== 522) begin n_fail++; $display("FAIL mid_l1: got %0d want 522", o1); end
    tick();
    n_chk++; if (bi.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b want 0", bi.out_valid); end
  endtask

  task automatic test_sweep();
    int qa[$], qa4[$];
    bit qf[$], qf4[$];
    int nv = 65536 / 13 + 1;
    int base, ai, oi;
    bit f, ok;
    logic signed [W-1:0] sv;
    bi.out_ready = 1'b1; bi4.out_ready = 1'b1;
    for (int n = 0; n < 2 * nv + 6; n++) begin
      bi.in_valid = (n < 2 * nv); bi4.in_valid = (n < 2 * nv);
      if (n < 2 * nv) begin
        base = -32768 + (n % nv) * 13; f = (n >= nv);
        for (int i = 0; i < L; i++)  bi.in_data[i]  = W'(base + i);
        for (int i = 0; i < L4; i++) bi4.in_data[i] = W'(base + i);
        bi.in_full = f; bi4.in_full = f;
        qa.push_back(base); qf.push_back(f); qa4.push_back(base); qf4.push_back(f);
      end
      tick();
      if (bi.out_valid) begin
        n_chk++;
        if (qa.size() == 0) begin n_fail++; $display("FAIL sweep_q_extra: got extra beat want none"); end
        else begin
          base = qa.pop_front(); f = qf.pop_front();
          for (int i = 0; i < L; i++) begin
            sv = W'(base + i); ai = sv; sv = bi.out_data[i]; oi = sv;
            ok = ((oi - ai) % Q == 0) && (f ? (oi >= 0 && oi < Q) : (oi >= -(Q - 1) / 2 && oi <= (Q - 1) / 2));
            n_chk++;
            if (!ok) begin n_fail++; $display("FAIL sweep_q: in %0d full %0d got %0d want congruent in range", ai, f, oi); end
          end
        end
      end
      if (bi4.out_valid) begin
        n_chk++;
        if (qa4.size() == 0) begin n_fail++; $display("FAIL sweep_q4_extra: got extra beat want none"); end
        else begin
          base = qa4.pop_front(); f = qf4.pop_front();
          for (int i = 0; i < L4; i++) begin
            sv = W'(base + i); ai = sv; sv = bi4.out_data[i]; oi = sv;
            ok = ((oi - ai) % Q4 == 0) && (f ? (oi >= 0 && oi < Q4) : (oi >= -(Q4 - 1) / 2 && oi <= (Q4 - 1) / 2));
            n_chk++;
            if (!ok) begin n_fail++; $display("FAIL sweep_q4: in %0d full %0d got %0d want congruent in range", ai, f, oi); end
          end
        end
      end
    end
    n_chk++; if (qa.size() != 0) begin n_fail++; $display("FAIL sweep_q_lost: got %0d pending want 0", qa.size()); end
    n_chk++; if (qa4.size() != 0) begin n_fail++; $display("FAIL sweep_q4_lost: got %0d pending want 0", qa4.size()); end
  endtask

  initial begin
    bi.in_valid = 1'b0; bi.in_data = '0; bi.in_full = 1'b0; bi.in_tag = '0; bi.out_ready = 1'b1;
    bi4.in_valid = 1'b0; bi4.in_data = '0; bi4.in_full = 1'b0; bi4.in_tag = '0; bi4.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_modes();
    test_boundary();
    test_back_to_back();
    test_reset_midstream();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
